// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage and IF/ID pipeline register.
//
// Boots the 32-bit PC from a two-word reset vector at instruction-memory
// addresses 0 (PC[31:16]) and 1 (PC[15:0]). It then fetches one 16-bit word
// per cycle into IF/ID. The word that follows an LDM opcode is tagged as an
// immediate. Stalls, branch redirects, stack-popped return addresses and
// (optionally) interrupts are applied here.
//
// Optional feature: define FETCH_INT_EN to build interrupt support (pending
// flag, acceptance, int_ack). Without it, interrupt is ignored and int_ack
// is tied 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fetch_pc_enable   0 = stall (hold PC, IF/ID and state)
//   pc_sel            00 seq, 01 branch, 10 stack pop, 11 interrupt
//   branch_taken      qualifies pc_sel = 01
//   pc_jmp            branch target
//   pop_pc1/pop_pc2   mem_data carries PC[31:16] / PC[15:0] (pop_pc2 completes)
//   mem_data          data-memory read word
//   interrupt         interrupt request
//   imem_addr         instruction-memory address (combinational read)
//   imem_data         word at imem_addr, same cycle
//   instruction       IF/ID instruction word
//   imm_word          instruction is an LDM immediate
//   pc_next           IF/ID address following instruction (return address)
//   int_ack           one-cycle pulse, interrupt accepted
//   boot_done         PC has been loaded from the reset vector
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_pc_enable,
    input  logic [1:0]  pc_sel,
    input  logic        branch_taken,
    input  logic [31:0] pc_jmp,
    input  logic        pop_pc1,
    input  logic        pop_pc2,
    input  logic [15:0] mem_data,
    input  logic        interrupt,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic        imm_word,
    output logic [31:0] pc_next,
    output logic        int_ack,
    output logic        boot_done
);

    localparam logic [4:0]  LdmOpcode = 5'b11000;
    localparam logic [31:0] IntVector = 32'h0000_0002;
    localparam logic [15:0] NopWord   = 16'h0000;

    typedef enum logic [1:0] {StBoot0, StBoot1, StRun, StImm} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] pc_hi_q, pc_hi_d;
    logic [15:0] instr_q, instr_d;
    logic        imm_q, imm_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        boot_done_q, boot_done_d;

    logic        is_ldm;
    logic        pop_redir;
    logic        br_redir;
    logic        int_accept;
    logic [31:0] pc_inc;

    assign is_ldm    = (imem_data[15:11] == LdmOpcode);
    assign pop_redir = pop_pc2 && (pc_sel == 2'b10);
    assign br_redir  = (pc_sel == 2'b01) && branch_taken;
    assign pc_inc    = pc_q + 32'd1;

`ifdef FETCH_INT_EN
    logic int_pend_q, int_pend_d;
    logic int_prev_q;
    logic int_ack_q, int_ack_d;
    logic int_rise;

    assign int_rise = interrupt && !int_prev_q;

    // Never accepted on an LDM word, so an opcode and its immediate are not split.
    assign int_accept = int_pend_q && (state_q == StRun) && !pop_redir && !br_redir &&
                        fetch_pc_enable && !is_ldm;

    always_comb begin
        int_ack_d = int_accept;
        // A rise while already pending merges into the pending request.
        if (int_pend_q) begin
            int_pend_d = !int_accept;
        end else begin
            int_pend_d = int_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_pend_q <= 1'b0;
            int_prev_q <= 1'b0;
            int_ack_q  <= 1'b0;
        end else begin
            int_pend_q <= int_pend_d;
            int_prev_q <= interrupt;
            int_ack_q  <= int_ack_d;
        end
    end

    assign int_ack = int_ack_q;
`else
    logic unused_interrupt;

    assign unused_interrupt = interrupt;
    assign int_accept       = 1'b0;
    assign int_ack          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot0;
            pc_q        <= 32'd0;
            pc_hi_q     <= 16'd0;
            instr_q     <= NopWord;
            imm_q       <= 1'b0;
            pc_next_q   <= 32'd0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_hi_q     <= pc_hi_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            pc_next_q   <= pc_next_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot0: state_d = StBoot1;
            StBoot1: state_d = StRun;
            StRun, StImm: begin
                if (pop_redir || br_redir) begin
                    state_d = StRun;
                end else if (!fetch_pc_enable) begin
                    state_d = state_q;
                end else if (int_accept) begin
                    state_d = StRun;
                end else if ((state_q == StRun) && is_ldm) begin
                    state_d = StImm;
                end else begin
                    state_d = StRun;
                end
            end
            default: state_d = StBoot0;
        endcase
    end

    // Datapath and outputs.
    always_comb begin
        pc_d        = pc_q;
        pc_hi_d     = pc_hi_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        pc_next_d   = pc_next_q;
        boot_done_d = boot_done_q;
        imem_addr   = pc_q;

        unique case (state_q)
            StBoot0: begin
                imem_addr = 32'd0;
                pc_hi_d   = imem_data;
            end
            StBoot1: begin
                imem_addr   = 32'd1;
                pc_d        = {pc_hi_q, imem_data};
                boot_done_d = 1'b1;
            end
            StRun, StImm: begin
                // The high half of a return address survives stalls.
                if (pop_pc1) begin
                    pc_hi_d = mem_data;
                end
                if (pop_redir) begin
                    pc_d    = {pc_hi_q, mem_data};
                    instr_d = NopWord;
                    imm_d   = 1'b0;
                end else if (br_redir) begin
                    pc_d    = pc_jmp;
                    instr_d = NopWord;
                    imm_d   = 1'b0;
                end else if (!fetch_pc_enable) begin
                    pc_d = pc_q;
                end else if (int_accept) begin
                    pc_d      = IntVector;
                    instr_d   = NopWord;
                    imm_d     = 1'b0;
                    pc_next_d = pc_q;
                end else begin
                    pc_d      = pc_inc;
                    instr_d   = imem_data;
                    imm_d     = (state_q == StImm);
                    pc_next_d = pc_inc;
                end
            end
            default: imem_addr = pc_q;
        endcase
    end

    assign instruction = instr_q;
    assign imm_word    = imm_q;
    assign pc_next     = pc_next_q;
    assign boot_done   = boot_done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each stimulus step pushes the outputs
// expected after the coming clock edge; a negedge monitor pops and compares.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_pc_enable;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] pc_jmp;
    logic        pop_pc1;
    logic        pop_pc2;
    logic [15:0] mem_data;
    logic        interrupt;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic        imm_word;
    logic [31:0] pc_next;
    logic        int_ack;
    logic        boot_done;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_pc_enable (fetch_pc_enable),
        .pc_sel          (pc_sel),
        .branch_taken    (branch_taken),
        .pc_jmp          (pc_jmp),
        .pop_pc1         (pop_pc1),
        .pop_pc2         (pop_pc2),
        .mem_data        (mem_data),
        .interrupt       (interrupt),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .instruction     (instruction),
        .imm_word        (imm_word),
        .pc_next         (pc_next),
        .int_ack         (int_ack),
        .boot_done       (boot_done)
    );

    typedef struct {
        int unsigned cyc;
        string       nm;
        logic [15:0] instr;
        logic        imm;
        logic [31:0] pcn;
        logic        ack;
        logic        bd;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, expv);
        end
    endtask

    // Monitor: compares every expectation tagged for the edge just taken.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.nm, e.cyc, cyc);
            end else begin
                chk(e.nm, "instruction", {16'd0, instruction}, {16'd0, e.instr});
                chk(e.nm, "imm_word", {31'd0, imm_word}, {31'd0, e.imm});
                chk(e.nm, "pc_next", pc_next, e.pcn);
                chk(e.nm, "int_ack", {31'd0, int_ack}, {31'd0, e.ack});
                chk(e.nm, "boot_done", {31'd0, boot_done}, {31'd0, e.bd});
                chk(e.nm, "imem_addr", imem_addr, e.addr);
            end
        end
    end

    task automatic idle();
        rst             = 1'b0;
        fetch_pc_enable = 1'b1;
        pc_sel          = 2'b00;
        branch_taken    = 1'b0;
        pc_jmp          = 32'd0;
        pop_pc1         = 1'b0;
        pop_pc2         = 1'b0;
        mem_data        = 16'd0;
        interrupt       = 1'b0;
    endtask

    // Inputs are already driven; push outputs expected after the next edge.
    task automatic step(input string nm, input logic [15:0] instr, input logic imm,
                        input logic [31:0] pcn, input logic ack, input logic bd,
                        input logic [31:0] addr);
        exp_t x;
        x.cyc   = cyc + 1;
        x.nm    = nm;
        x.instr = instr;
        x.imm   = imm;
        x.pcn   = pcn;
        x.ack   = ack;
        x.bd    = bd;
        x.addr  = addr;
        sb.push_back(x);
        @(posedge clk);
        #2;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'h0040;
        mem[8'h40] = 16'hC100;
        mem[8'h41] = 16'h1234;
        mem[8'h44] = 16'hC1AA;
        idle();

        rst = 1'b1; step("reset0", 16'h0000, 0, 32'h0, 0, 0, 32'h0);
        rst = 1'b1; step("reset1", 16'h0000, 0, 32'h0, 0, 0, 32'h0);
        step("boot0", 16'h0000, 0, 32'h0, 0, 0, 32'h1);
        step("boot1", 16'h0000, 0, 32'h0, 0, 1, 32'h40);
        step("ldm_op", 16'hC100, 0, 32'h41, 0, 1, 32'h41);
        step("ldm_imm", 16'h1234, 1, 32'h42, 0, 1, 32'h42);
        step("seq42", 16'h2042, 0, 32'h43, 0, 1, 32'h43);
        for (int i = 0; i < 3; i++) begin
            fetch_pc_enable = 1'b0;
            step("stall", 16'h2042, 0, 32'h43, 0, 1, 32'h43);
        end
        step("seq43", 16'h2043, 0, 32'h44, 0, 1, 32'h44);
        step("ldm2_op", 16'hC1AA, 0, 32'h45, 0, 1, 32'h45);
        pc_sel = 2'b01; branch_taken = 1'b1; pc_jmp = 32'h80;
        step("br_in_imm", 16'h0000, 0, 32'h45, 0, 1, 32'h80);
        step("br_target", 16'h2080, 0, 32'h81, 0, 1, 32'h81);
        pc_sel = 2'b01; branch_taken = 1'b0; pc_jmp = 32'h10;
        step("br_not_taken", 16'h2081, 0, 32'h82, 0, 1, 32'h82);
        pop_pc1 = 1'b1; mem_data = 16'h0001;
        step("pop1", 16'h2082, 0, 32'h83, 0, 1, 32'h83);
        fetch_pc_enable = 1'b0; mem_data = 16'hFFFF;
        step("pop_stall", 16'h2082, 0, 32'h83, 0, 1, 32'h83);
        pop_pc2 = 1'b1; pc_sel = 2'b10; mem_data = 16'h0055;
        step("pop2", 16'h0000, 0, 32'h83, 0, 1, 32'h0001_0055);
        step("pop_target", 16'h2055, 0, 32'h0001_0056, 0, 1, 32'h0001_0056);
        pop_pc2 = 1'b1; mem_data = 16'h0077;
        step("pop2_no_sel", 16'h2056, 0, 32'h0001_0057, 0, 1, 32'h0001_0057);
        pc_sel = 2'b01; branch_taken = 1'b1; pc_jmp = 32'hFFFF_FFFF;
        step("br_top", 16'h0000, 0, 32'h0001_0057, 0, 1, 32'hFFFF_FFFF);
        step("wrap", 16'h20FF, 0, 32'h0, 0, 1, 32'h0);
        step("after_wrap", 16'h0000, 0, 32'h1, 0, 1, 32'h1);
        pc_sel = 2'b01; branch_taken = 1'b1; pc_jmp = 32'h44;
        step("br_ldm", 16'h0000, 0, 32'h1, 0, 1, 32'h44);
        interrupt = 1'b1; pc_sel = 2'b11;
        step("int_on_ldm", 16'hC1AA, 0, 32'h45, 0, 1, 32'h45);
        step("int_imm", 16'h2045, 1, 32'h46, 0, 1, 32'h46);
`ifdef FETCH_INT_EN
        step("int_accept", 16'h0000, 0, 32'h46, 1, 1, 32'h2);
        step("int_vector", 16'h2002, 0, 32'h3, 0, 1, 32'h3);
        interrupt = 1'b1; fetch_pc_enable = 1'b0;
        step("int_stalled", 16'h2002, 0, 32'h3, 0, 1, 32'h3);
        interrupt = 1'b1;
        step("int_accept2", 16'h0000, 0, 32'h3, 1, 1, 32'h2);
        step("int_vector2", 16'h2002, 0, 32'h3, 0, 1, 32'h3);
        fetch_pc_enable = 1'b0;
        step("stall_pre_rst", 16'h2002, 0, 32'h3, 0, 1, 32'h3);
`else
        step("int_ignored", 16'h2046, 0, 32'h47, 0, 1, 32'h47);
        interrupt = 1'b1; pc_sel = 2'b11;
        step("sel11_seq", 16'h2047, 0, 32'h48, 0, 1, 32'h48);
        fetch_pc_enable = 1'b0;
        step("stall_pre_rst", 16'h2047, 0, 32'h48, 0, 1, 32'h48);
`endif
        fetch_pc_enable = 1'b0; rst = 1'b1;
        step("rst_in_stall", 16'h0000, 0, 32'h0, 0, 0, 32'h0);
        step("reboot0", 16'h0000, 0, 32'h0, 0, 0, 32'h1);
        step("reboot1", 16'h0000, 0, 32'h0, 0, 1, 32'h40);
        step("refetch", 16'hC100, 0, 32'h41, 0, 1, 32'h41);
        rst = 1'b1;
        step("rst_in_imm", 16'h0000, 0, 32'h0, 0, 0, 32'h0);
        step("reboot_imm", 16'h0000, 0, 32'h0, 0, 0, 32'h1);

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
